riscv_icache_resp: RTL and testbench
====================================

Name: riscv_icache_resp

Overview:
- Instruction-side memory responder: the slave end of the fetch-to-icache request/response interface that riscv_fetch drives.
- Holds an internal word-addressed instruction RAM, loaded through a side write port.
- Accepts one read request per cycle and returns the instruction in order after a fixed latency, with fetch-fault and page-fault flags.
- Used as the icache stand-in for core-level simulation and FPGA bring-up.

Parameters:
- MEM_WORDS, 1024: instruction RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000: byte address of RAM word 0.
- RESP_LATENCY, 2: cycles from accepted request to req_valid_o; legal range 1..4.
- FLUSH_CYCLES, 4: cycles req_accept_o stays low after a flush or invalidate.
- USER_LIMIT, 32'h8000_0800: user-mode (priv 2'b00) fetches at or above this address page-fault.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_rd_i  in  1  read request.
- req_pc_i  in  32  fetch byte address.
- req_priv_i  in  2  privilege of the request: 00=U, 01=S, 11=M.
- req_flush_i  in  1  flush pulse.
- req_invalidate_i  in  1  invalidate pulse.
- req_accept_o  out  1  request accepted this cycle.
- req_valid_o  out  1  response valid; single-cycle pulse per response.
- req_inst_o  out  32  instruction word.
- req_error_o  out  1  fetch fault.
- req_page_fault_o  out  1  page fault.
- load_wr_i  in  1  RAM write enable.
- load_addr_i  in  32  RAM write byte address.
- load_data_i  in  32  RAM write data.

Behaviour:
- Reset values: req_accept_o=0, req_valid_o=0, req_inst_o=0, req_error_o=0, req_page_fault_o=0, state=IDLE, pipeline empty. RAM contents are not reset.
- After reset deasserts, req_accept_o=1 from the first IDLE cycle.
- Handshake: a request transfers when req_rd_i && req_accept_o. There is no response backpressure, and up to RESP_LATENCY requests may be in flight.
- req_accept_o is combinational from the state only; it never depends on req_rd_i.
- Latency: a request accepted in cycle N produces req_valid_o=1 in cycle N+RESP_LATENCY. Responses are strictly in order.
- Address check, evaluated at accept:
  - index = (pc - BASE_ADDR) >> 2.
  - Out of range (pc < BASE_ADDR, or index >= MEM_WORDS) or pc[1:0] != 0: req_error_o=1, req_inst_o=0.
  - Otherwise, if priv==00 and pc >= USER_LIMIT: req_page_fault_o=1, req_inst_o=0.
  - Error has priority over page fault; the two flags are never both 1.
- RAM read is read-before-write: a load write to the same word in the accept cycle does not affect that response. The load port is always active, regardless of state.
- Out-of-range load writes are ignored.
- The output flags and req_inst_o are zero whenever req_valid_o=0.
- FSM states:
  - IDLE: accept=1. req_flush_i or req_invalidate_i -> FLUSH, with counter=FLUSH_CYCLES-1.
  - FLUSH: accept=0, counter decrements each cycle. At 0 -> IDLE.
  - A new flush or invalidate while in FLUSH reloads the counter.
- req_flush_i: in-flight responses drain normally.
- req_invalidate_i: all in-flight entries are killed in the same cycle. No req_valid_o appears for any request accepted before or in that cycle.
- A request presented in the same cycle as flush or invalidate is still accepted, because accept is decided from the current state (IDLE). It is killed if invalidate, and returned if flush.
- Reset mid-operation clears the pipeline immediately; no pending response is emitted.
- Address arithmetic is 32-bit unsigned with no wrap: pc below BASE_ADDR is an error, not an alias.

Decomposition:
- Package riscv_icache_defs:
  - PRIV_U/S/M constants.
  - State enum {IDLE, FLUSH}.
  - Response struct {valid, inst, error, page_fault}.
- Sub-module riscv_icache_resp_pipe:
  - RESP_LATENCY-deep shift register of the response struct.
  - Synchronous kill input clears every stage's valid bit.
- The top level holds the FSM, address check and RAM.

Test Plan:
1. Load word 0=32'h0000_0013 and word 1=32'h0010_0093. Request pc 8000_0000 then 8000_0004 back-to-back, priv=11 -> valid in cycles N+2 and N+3 with those words, no flags, accept held at 1.
2. Request pc 32'hFACE_BEEF at priv 11 -> error=1, inst=0. Request pc 8000_1000 -> error=1. Request pc 8000_0002 -> error=1.
3. Request pc 8000_0800 at priv 00 -> page_fault=1, error=0. Same pc at priv 01 -> normal data.
4. Issue 2 requests, then req_invalidate_i one cycle after the second -> no req_valid_o at all; accept=0 for exactly 4 cycles, then 1.
5. Same sequence as scenario 4 with req_flush_i -> both responses delivered with correct data; accept=0 for 4 cycles.
6. Assert rst_i while 2 requests are in flight -> all outputs are 0 immediately and no valid follows. Also cover a load write to word 3 in the same cycle a read of 8000_000C is accepted -> the read returns the old value.

Source files
------------

// File: rtl/riscv_icache_resp_pkg.sv
// Shared definitions for the instruction-side memory responder.
//   PRIV_*  : request privilege encodings
//   state_e : request-acceptance FSM states
//   resp_t  : one response slot as it travels through the latency pipe
package riscv_icache_defs;

   localparam int unsigned INST_W = 32;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   typedef struct packed {
      logic              valid;
      logic [INST_W-1:0] inst;
      logic              error;
      logic              page_fault;
   } resp_t;

endpackage

// File: rtl/riscv_icache_resp_pipe.sv
// Fixed-latency response pipe: DEPTH-stage shift register of resp_t.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   kill_i       : synchronous kill, empties every stage (including the one being loaded)
//   in_i         : response entering the pipe this cycle
//   out_o        : response leaving the pipe (registered)
module riscv_icache_resp_pipe
   import riscv_icache_defs::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  kill_i,
   input  resp_t in_i,
   output resp_t out_o
);

   resp_t stage_q [DEPTH];
   resp_t stage_d [DEPTH];

   // Shift by one stage per cycle; a kill clears whole entries so flags/data stay zero
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_d[i] = '0;
      end
      if (!kill_i) begin
         stage_d[0] = in_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/riscv_icache_resp.sv
// Instruction-side memory responder (icache stand-in for core simulation / FPGA bring-up).
// Word-addressed instruction RAM loaded via a side port; in-order responses after
// RESP_LATENCY cycles with fetch-fault and page-fault flags.
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   req_rd_i/pc/priv           : fetch request (transfers on req_rd_i && req_accept_o)
//   req_flush_i                : stall acceptance FLUSH_CYCLES cycles, in-flight drains
//   req_invalidate_i           : as flush, and kills all in-flight responses at once
//   req_accept_o               : acceptance, from FSM state only
//   req_valid_o/inst/error/pf  : response, zero-valued when not valid
//   load_wr_i/addr/data        : RAM write port, always active
module riscv_icache_resp
   import riscv_icache_defs::*;
#(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int unsigned RESP_LATENCY = 2,
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter logic [31:0] USER_LIMIT   = 32'h8000_0800
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_rd_i,
   input  logic [31:0] req_pc_i,
   input  logic [1:0]  req_priv_i,
   input  logic        req_flush_i,
   input  logic        req_invalidate_i,
   output logic        req_accept_o,
   output logic        req_valid_o,
   output logic [31:0] req_inst_o,
   output logic        req_error_o,
   output logic        req_page_fault_o,
   input  logic        load_wr_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_data_i
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_any;

   // Acceptance FSM: state and flush counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign flush_any = req_flush_i | req_invalidate_i;

   // A flush/invalidate arriving while already flushing restarts the count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (flush_any) begin
               state_d = FLUSH;
               cnt_d   = CNT_RELOAD;
            end
         end
         FLUSH: begin
            if (flush_any) begin
               cnt_d = CNT_RELOAD;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Held low while in reset so nothing is seen as accepted
   assign req_accept_o = (state_q == IDLE) && !rst_i;

   // Address decode; subtraction only meaningful when pc >= BASE_ADDR (no wrap aliasing)
   logic [31:0]      rd_off, ld_off;
   logic             rd_in_range, ld_in_range;
   logic [IDX_W-1:0] rd_idx, ld_idx;

   assign rd_off      = req_pc_i - BASE_ADDR;
   assign rd_in_range = (req_pc_i >= BASE_ADDR) && ((rd_off >> 2) < 32'(MEM_WORDS));
   assign rd_idx      = IDX_W'(rd_off >> 2);

   assign ld_off      = load_addr_i - BASE_ADDR;
   assign ld_in_range = (load_addr_i >= BASE_ADDR) && ((ld_off >> 2) < 32'(MEM_WORDS));
   assign ld_idx      = IDX_W'(ld_off >> 2);

   // Instruction RAM: async read feeds the pipe, so a same-cycle write lands after the read
   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk_i) begin
      if (load_wr_i && ld_in_range) begin
         mem[ld_idx] <= load_data_i;
      end
   end

   // Build the response at accept time; error outranks page fault
   resp_t resp_in;
   logic  fire;

   assign fire = req_rd_i && req_accept_o;

   always_comb begin
      resp_in = '0;
      if (fire) begin
         resp_in.valid = 1'b1;
         if (!rd_in_range || (req_pc_i[1:0] != 2'b00)) begin
            resp_in.error = 1'b1;
         end else if ((req_priv_i == PRIV_U) && (req_pc_i >= USER_LIMIT)) begin
            resp_in.page_fault = 1'b1;
         end else begin
            resp_in.inst = mem[rd_idx];
         end
      end
   end

   resp_t resp_out;

   riscv_icache_resp_pipe #(
      .DEPTH (RESP_LATENCY)
   ) u_pipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .kill_i (req_invalidate_i),
      .in_i   (resp_in),
      .out_o  (resp_out)
   );

   // Invalidate also suppresses the response leaving the pipe in that same cycle
   logic out_live;

   assign out_live         = resp_out.valid && !req_invalidate_i;
   assign req_valid_o      = out_live;
   assign req_inst_o       = out_live ? resp_out.inst : 32'h0;
   assign req_error_o      = out_live && resp_out.error;
   assign req_page_fault_o = out_live && resp_out.page_fault;

endmodule

// File: tb/tb_riscv_icache_resp.sv
// Directed bench for riscv_icache_resp: per-cycle vector table plus hand sequences
// for read-before-write and reset with requests in flight.
module tb_riscv_icache_resp;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_rd_i;
   logic [31:0] req_pc_i;
   logic [1:0]  req_priv_i;
   logic        req_flush_i;
   logic        req_invalidate_i;
   logic        req_accept_o;
   logic        req_valid_o;
   logic [31:0] req_inst_o;
   logic        req_error_o;
   logic        req_page_fault_o;
   logic        load_wr_i;
   logic [31:0] load_addr_i;
   logic [31:0] load_data_i;

   int n_cmp = 0;
   int n_bad = 0;

   riscv_icache_resp dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .req_rd_i         (req_rd_i),
      .req_pc_i         (req_pc_i),
      .req_priv_i       (req_priv_i),
      .req_flush_i      (req_flush_i),
      .req_invalidate_i (req_invalidate_i),
      .req_accept_o     (req_accept_o),
      .req_valid_o      (req_valid_o),
      .req_inst_o       (req_inst_o),
      .req_error_o      (req_error_o),
      .req_page_fault_o (req_page_fault_o),
      .load_wr_i        (load_wr_i),
      .load_addr_i      (load_addr_i),
      .load_data_i      (load_data_i)
   );

   always #5 clk_i = ~clk_i;

   // One record = inputs driven for one cycle and the outputs required in that cycle
   typedef struct {
      logic        rd;
      logic [31:0] pc;
      logic [1:0]  priv;
      logic        fl;
      logic        inv;
      logic        acc;
      logic        vld;
      logic [31:0] inst;
      logic        err;
      logic        pf;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rd, logic [31:0] pc, logic [1:0] priv, logic fl, logic inv,
                               logic acc, logic vld, logic [31:0] inst, logic err, logic pf);
      vec_t v;
      v.rd = rd; v.pc = pc; v.priv = priv; v.fl = fl; v.inv = inv;
      v.acc = acc; v.vld = vld; v.inst = inst; v.err = err; v.pf = pf;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, required %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx, input logic acc, input logic vld,
                          input logic [31:0] inst, input logic err, input logic pf);
      chk({tag, ".accept"}, idx, 32'(req_accept_o), 32'(acc));
      chk({tag, ".valid"},  idx, 32'(req_valid_o),  32'(vld));
      chk({tag, ".inst"},   idx, req_inst_o,        inst);
      chk({tag, ".error"},  idx, 32'(req_error_o),  32'(err));
      chk({tag, ".pfault"}, idx, 32'(req_page_fault_o), 32'(pf));
   endtask

   task automatic idle_inputs();
      req_rd_i = 1'b0; req_pc_i = 32'h0; req_priv_i = 2'b11;
      req_flush_i = 1'b0; req_invalidate_i = 1'b0;
      load_wr_i = 1'b0; load_addr_i = 32'h0; load_data_i = 32'h0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk_i);
      load_wr_i = 1'b1; load_addr_i = addr; load_data_i = data;
      @(negedge clk_i);
      load_wr_i = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst_i = 1'b1;

      // Reset state
      repeat (2) @(negedge clk_i);
      #1 chk_all("reset", 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1 chk("post_reset.accept", 0, 32'(req_accept_o), 32'h1);

      // RAM image; the out-of-range write would alias word 0 if not rejected
      load(32'h8000_0000, 32'h0000_0013);
      load(32'h8000_0004, 32'h0010_0093);
      load(32'h8000_000C, 32'hAAAA_0003);
      load(32'h8000_0800, 32'h1234_5678);
      load(32'h8000_1000, 32'hDEAD_BEEF);

      //        rd   pc             pr     fl   inv  acc  vld  inst           err  pf
      // Back-to-back hits, latency 2
      vq.push_back(mk(1, 32'h8000_0000, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_0004, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 1, 32'h0000_0013,  0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 1, 32'h0010_0093,  0, 0));
      // Fetch faults: wild pc, one past the end, misaligned
      vq.push_back(mk(1, 32'hFACE_BEEF, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_1000, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_0002, 2'b11, 0, 0, 1, 1, 32'h0,          1, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 1, 32'h0,          1, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 1, 32'h0,          1, 0));
      // Page fault for U at USER_LIMIT; S at same pc reads data
      vq.push_back(mk(1, 32'h8000_0800, 2'b00, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_0800, 2'b01, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 1, 32'h0,          0, 1));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 1, 32'h1234_5678,  0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      // Invalidate one cycle after second request: nothing returns, 4 cycles no accept
      vq.push_back(mk(1, 32'h8000_0000, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_0004, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 1, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_0000, 2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      // Flush instead: both responses drain
      vq.push_back(mk(1, 32'h8000_0000, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(1, 32'h8000_0004, 2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 1, 0, 1, 1, 32'h0000_0013,  0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 1, 32'h0010_0093,  0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      // Request alongside invalidate: accepted, then killed
      vq.push_back(mk(1, 32'h8000_0000, 2'b11, 0, 1, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      // Request alongside flush: accepted and returned
      vq.push_back(mk(1, 32'h8000_0004, 2'b11, 1, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 1, 32'h0010_0093,  0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 0, 32'h0,          0, 0));
      // Flush during FLUSH reloads the counter
      vq.push_back(mk(0, 32'h0,         2'b11, 1, 0, 1, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 1, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 0, 0, 32'h0,          0, 0));
      vq.push_back(mk(0, 32'h0,         2'b11, 0, 0, 1, 0, 32'h0,          0, 0));

      foreach (vq[i]) begin
         @(negedge clk_i);
         req_rd_i = vq[i].rd; req_pc_i = vq[i].pc; req_priv_i = vq[i].priv;
         req_flush_i = vq[i].fl; req_invalidate_i = vq[i].inv;
         #1 chk_all("vec", i, vq[i].acc, vq[i].vld, vq[i].inst, vq[i].err, vq[i].pf);
      end
      @(negedge clk_i);
      idle_inputs();

      // Read-before-write on word 3
      @(negedge clk_i);
      req_rd_i = 1'b1; req_pc_i = 32'h8000_000C;
      load_wr_i = 1'b1; load_addr_i = 32'h8000_000C; load_data_i = 32'hBBBB_0003;
      #1 chk("rbw.accept", 0, 32'(req_accept_o), 32'h1);
      @(negedge clk_i);
      idle_inputs();
      #1 chk("rbw.valid_early", 1, 32'(req_valid_o), 32'h0);
      @(negedge clk_i);
      #1 chk_all("rbw.old", 2, 1'b1, 1'b1, 32'hAAAA_0003, 1'b0, 1'b0);
      req_rd_i = 1'b1; req_pc_i = 32'h8000_000C;
      @(negedge clk_i);
      idle_inputs();
      @(negedge clk_i);
      #1 chk_all("rbw.new", 3, 1'b1, 1'b1, 32'hBBBB_0003, 1'b0, 1'b0);

      // Reset with two requests in flight
      @(negedge clk_i);
      req_rd_i = 1'b1; req_pc_i = 32'h8000_0000;
      @(negedge clk_i);
      req_pc_i = 32'h8000_0004;
      @(negedge clk_i);
      idle_inputs();
      rst_i = 1'b1;
      #1 chk_all("rst_mid", 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i);
         #1 chk_all("rst_after", k, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
